// File: rtl/debounce_sync_pkg.sv
// Shared types and default constants for the debounce_sync block.
// The FSM state type is also used by the debug state output.
package debounce_sync_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_COUNT    = 4;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_t;

  // The debounced level is a pure function of the state.
  function automatic logic state_level(input db_state_t st);
    return (st == STABLE_HI) || (st == WAIT_LO);
  endfunction

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Multi-flop synchronizer bringing the raw asynchronous input into clk.
// Cleared by the asynchronous reset only; the preset does not touch it.
module sync_chain
  import debounce_sync_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_s
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_s = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizing debouncer: q follows din only after DB_COUNT consecutive differing samples.
// Optional macro DEBOUNCE_SYNC_EDGE_EN enables the registered rise/fall pulses.
module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter  int DB_COUNT    = DEF_DB_COUNT,
  localparam int CW          = $clog2(DB_COUNT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          set_n,
  input  logic          din,
  output logic          q,
  output logic          rise,
  output logic          fall,
  output logic          busy,
  output db_state_t     dbg_state,
  output logic [CW-1:0] dbg_cnt
);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

  db_state_t     r_state;
  db_state_t     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_s;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .i_d    (din),
    .o_s    (w_s)
  );

  // The preset overrides any qualification in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
    end else if (!set_n) begin
      r_state <= STABLE_HI;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Reaching CNT_LAST while still differing means this edge completes DB_COUNT samples.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      STABLE_LO: begin
        if (w_s) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!w_s) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!w_s) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (w_s) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    q         = state_level(r_state);
    busy      = (r_state == WAIT_HI) || (r_state == WAIT_LO);
    dbg_state = r_state;
    dbg_cnt   = r_cnt;
  end

`ifdef DEBOUNCE_SYNC_EDGE_EN
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (!set_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= (r_state == WAIT_HI) && (w_state_nxt == STABLE_HI);
      r_fall <= (r_state == WAIT_LO) && (w_state_nxt == STABLE_LO);
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: run-length reference model compared every
// cycle, plus directed scenarios with hand-computed edge-by-edge expectations.
module tb_debounce_sync;
  import debounce_sync_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int DB_COUNT    = 4;
  localparam int CW          = $clog2(DB_COUNT + 1);
`ifdef DEBOUNCE_SYNC_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          set_n;
  logic          din;
  logic          q;
  logic          rise;
  logic          fall;
  logic          busy;
  db_state_t     dbg_state;
  logic [CW-1:0] dbg_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  debounce_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_COUNT   (DB_COUNT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_n    (set_n),
    .din      (din),
    .q        (q),
    .rise     (rise),
    .fall     (fall),
    .busy     (busy),
    .dbg_state(dbg_state),
    .dbg_cnt  (dbg_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  // q flips once the delayed input has differed from q for DB_COUNT edges in a row.
  logic [SYNC_STAGES-1:0] m_hist;
  logic m_q, m_rise, m_fall;
  int   m_run;

  always @(posedge clk or negedge reset_n) begin
    automatic logic s_seen;
    automatic int   run;
    automatic logic qn;
    if (!reset_n) begin
      m_hist <= '0;
      m_q    <= 1'b0;
      m_run  <= 0;
      m_rise <= 1'b0;
      m_fall <= 1'b0;
    end else begin
      s_seen = m_hist[SYNC_STAGES-1];
      run    = m_run;
      qn     = m_q;
      if (!set_n) begin
        qn  = 1'b1;
        run = 0;
      end else if (s_seen != m_q) begin
        run = run + 1;
        if (run == DB_COUNT) begin
          qn  = ~m_q;
          run = 0;
        end
      end else begin
        run = 0;
      end
      m_hist <= {m_hist[SYNC_STAGES-2:0], din};
      m_q    <= qn;
      m_run  <= run;
      m_rise <= EDGE && set_n && !m_q && qn;
      m_fall <= EDGE && m_q && !qn;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_q", int'(q), int'(m_q));
      check("model_busy", int'(busy), int'(m_run != 0));
      check("model_rise", int'(rise), int'(m_rise));
      check("model_fall", int'(fall), int'(m_fall));
      check("rise_fall_excl", int'(rise & fall), 0);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    set_n   = 1'b1;
    din     = 1'b0;
    step(2);
    check("reset_q", int'(q), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_rise", int'(rise), 0);
    check("reset_fall", int'(fall), 0);
    check("reset_cnt", int'(dbg_cnt), 0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    step(3);

    // Clean rising input: busy from edge 2, q at edge 5, one rise pulse.
    din = 1'b1;
    step(2);
    check("up_busy_e1", int'(busy), 0);
    step(1);
    check("up_busy_e2", int'(busy), 1);
    step(2);
    check("up_q_e4", int'(q), 0);
    step(1);
    check("up_q_e5", int'(q), 1);
    check("up_rise_e5", int'(rise), int'(EDGE));
    step(1);
    check("up_rise_e6", int'(rise), 0);
    check("up_busy_e6", int'(busy), 0);
    step(2);

    // Asynchronous reset with q=1, mid low phase, no clock edge involved.
    #3 reset_n = 1'b0;
    #1;
    check("areset_q", int'(q), 0);
    check("areset_busy", int'(busy), 0);
    check("areset_rise", int'(rise), 0);
    check("areset_fall", int'(fall), 0);
    din = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(8);

    // Reset pulse during WAIT_HI with cnt=2 restarts the full qualification.
    din = 1'b1;
    step(4);
    check("mid_cnt_e3", int'(dbg_cnt), 2);
    check("mid_busy_e3", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset_q", int'(q), 0);
    check("mid_reset_cnt", int'(dbg_cnt), 0);
    #4 reset_n = 1'b1;
    step(5);
    check("restart_q_e4", int'(q), 0);
    step(1);
    check("restart_q_e5", int'(q), 1);
    check("restart_rise_e5", int'(rise), int'(EDGE));
    din = 1'b0;
    step(10);
    check("down_settled_q", int'(q), 0);

    // Two-cycle glitch: qualification starts then aborts with no pulse.
    din = 1'b1;
    step(2);
    din = 1'b0;
    step(2);
    check("glitch_busy_e3", int'(busy), 1);
    step(1);
    check("glitch_busy_e4", int'(busy), 0);
    step(5);
    check("glitch_q", int'(q), 0);

    // Preset with din low: q=1 at once, then falls DB_COUNT edges later.
    set_n = 1'b0;
    step(1);
    check("preset_q", int'(q), 1);
    check("preset_rise", int'(rise), 0);
    set_n = 1'b1;
    step(3);
    check("preset_q_s3", int'(q), 1);
    check("preset_busy_s3", int'(busy), 1);
    step(1);
    check("preset_q_s4", int'(q), 0);
    check("preset_fall_s4", int'(fall), int'(EDGE));
    step(1);
    check("preset_fall_s5", int'(fall), 0);
    step(4);

    // Bounce every cycle, then settle high: q rises at edge 5 of the final capture.
    for (int i = 0; i < 6; i++) begin
      din = ~din;
      step(1);
    end
    din = 1'b1;
    step(5);
    check("bounce_q_e4", int'(q), 0);
    step(1);
    check("bounce_q_e5", int'(q), 1);
    check("bounce_rise_e5", int'(rise), int'(EDGE));
    din = 1'b0;
    step(10);

    // Reset dominates a simultaneous preset; preset works once reset releases.
    reset_n = 1'b0;
    set_n   = 1'b0;
    step(1);
    check("prio_q", int'(q), 0);
    reset_n = 1'b1;
    step(1);
    check("prio_set_q", int'(q), 1);
    set_n = 1'b1;
    din   = 1'b1;
    step(8);
    check("prio_hold_q", int'(q), 1);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on din (legal 2..4).
REQ-002 The block SHALL have parameter DB_COUNT, default 4, meaning the consecutive sampled cycles of changed input required to update q (legal 2..255).
REQ-003 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port set_n, input, 1 bit, a synchronous active-low preset of q to 1.
REQ-006 The block SHALL have port din, input, 1 bit, the raw asynchronous bouncing input.
REQ-007 The block SHALL have port q, output, 1 bit, the debounced level that feeds the downstream D flip-flop d input.
REQ-008 The block SHALL have port rise, output, 1 bit, a one-cycle pulse on the clock edge where q goes 0->1.
REQ-009 The block SHALL have port fall, output, 1 bit, a one-cycle pulse on the clock edge where q goes 1->0.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a candidate change is being qualified.
REQ-011 The block SHALL use one clock, clk, and an asynchronous active-low reset, reset_n.

Function
REQ-012 din SHALL pass through SYNC_STAGES flops; s denotes the last stage.
REQ-013 The FSM SHALL have states STABLE_LO, WAIT_HI, STABLE_HI and WAIT_LO, with q=1 exactly in STABLE_HI and WAIT_LO.
REQ-014 In STABLE_LO with s=1 sampled, the FSM SHALL go to WAIT_HI with cnt=1; in STABLE_HI with s=0, it SHALL go to WAIT_LO with cnt=1.
REQ-015 In WAIT_* with s still differing from q, cnt SHALL increment; at the edge where cnt would reach DB_COUNT, q SHALL toggle, the FSM SHALL move to the opposite STABLE_* state, and cnt SHALL clear to 0.
REQ-016 In WAIT_* with s equal to q (a glitch), the FSM SHALL return to its STABLE_* state with cnt=0, leaving q unchanged and producing no pulse.
REQ-017 q SHALL change exactly at edge SYNC_STAGES+DB_COUNT-1, counting the first edge that captures the new din as edge 0 (defaults: edge 5).
REQ-018 rise/fall SHALL be registered and high for exactly the one cycle following the edge at which q toggles, and SHALL never be high together.
REQ-019 busy SHALL equal 1 in WAIT_HI and WAIT_LO and 0 otherwise.
REQ-020 cnt SHALL be $clog2(DB_COUNT+1) bits wide and SHALL never exceed DB_COUNT (no wrap-around).
REQ-021 set_n=0 at an edge SHALL force q=1, STABLE_HI and cnt=0, with no rise pulse, overriding all FSM activity; synchronizer flops SHALL be unaffected.

Reset
REQ-022 reset_n=0 SHALL immediately, without a clock, force q=0, rise=0, fall=0, busy=0, cnt=0, state STABLE_LO and all synchronizer flops to 0.
REQ-023 reset_n SHALL take priority over set_n; after release, operation SHALL resume from STABLE_LO at the next edge.

Configuration
REQ-024 Macro DEBOUNCE_SYNC_EDGE_EN: when defined, rise/fall SHALL be generated per REQ-018; when undefined, the edge logic SHALL be omitted and rise/fall SHALL be tied to constant 0 (ports remain).

Structure
REQ-025 Package debounce_sync_pkg SHALL hold the FSM state enum type and the default constants for SYNC_STAGES and DB_COUNT.
REQ-026 The synchronizer SHALL be a separate sub-module, sync_chain, parameterized by SYNC_STAGES and reset by reset_n.

Verification (SYNC_STAGES=2, DB_COUNT=4, clock period 20 ns, DEBOUNCE_SYNC_EDGE_EN defined)
REQ-027 Assert reset_n=0 at 3 ns after a negedge with q=1 -> q=0 and busy=0 with no clock edge; rise and fall remain 0.
REQ-028 din 0->1 held -> busy=1 from edge 2, q=1 at edge 5, rise=1 for one cycle only, busy=0 afterwards.
REQ-029 din high for 2 cycles then low -> q stays 0, no rise pulse, busy returns to 0.
REQ-030 set_n=0 for one edge with q=0 and din=0 -> q=1 at that edge with no rise pulse; after release, q=0 with fall pulse DB_COUNT edges later.
REQ-031 reset_n pulsed low for 5 ns during WAIT_HI at cnt=2 -> q=0 and cnt=0; the full 6-edge qualification restarts after release.
REQ-032 din toggling every cycle for 6 cycles then held at 1 -> no pulses during bounce; q rises 5 edges after the final transition is captured.
